// File: rtl/sram_wstrb_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte-strobe SRAM,
// with per-port burst locking and a one-cycle read response path.
module sram_wstrb_arbiter #(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int WSTRB_W   = DATA_W / 8,
  parameter int BURST_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_wen,
  input  logic [1:0]             req_last,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [2*DATA_W-1:0]    req_wdata,
  input  logic [2*WSTRB_W-1:0]   req_wstrb,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  output logic [WSTRB_W-1:0]     sram_wstrb,
  input  logic [DATA_W-1:0]      sram_rdata
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
  localparam logic CAN_LOCK = (BURST_MAX > 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_limit;
  logic [1:0]       grant;
  logic [1:0]       fire;
  logic             any_fire;
  logic             sel;

  // Grant depends only on state and valids so ready never loops through data.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
          else            grant = req_valid;
        end
        LOCK0:   grant = {1'b0, req_valid[0]};
        LOCK1:   grant = {req_valid[1], 1'b0};
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign fire      = req_valid & grant;
  assign any_fire  = |fire;
  assign sel       = fire[1];

  assign sram_cen   = any_fire;
  assign sram_wen   = any_fire & req_wen[sel];
  assign sram_addr  = !any_fire ? '0 :
                      sel ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign sram_wdata = !any_fire ? '0 :
                      sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign sram_wstrb = !any_fire ? '0 :
                      sel ? req_wstrb[WSTRB_W +: WSTRB_W] : req_wstrb[0 +: WSTRB_W];

  assign rsp_rdata = sram_rdata;

  assign cnt_inc  = beat_cnt + CNT_W'(1);
  assign at_limit = (cnt_inc == BURST_LIM);

  // Control state: arbitration history, burst lock and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      rsp_valid  <= 2'b00;
    end else begin
      rsp_valid <= fire & ~req_wen;
      if (any_fire) last_grant <= sel;
      case (state)
        IDLE: begin
          if (any_fire && !req_last[sel] && CAN_LOCK) begin
            state    <= sel ? LOCK1 : LOCK0;
            beat_cnt <= CNT_W'(1);
          end
        end
        LOCK0, LOCK1: begin
          // Forced release at the beat limit keeps one port from starving the other.
          if (any_fire) begin
            if (req_last[sel] || at_limit) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule
